// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter.
// Inhibit, request-to-send, clock out 11-bit frame, check device ACK.
module ps2_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000,
  parameter int unsigned CNT_WIDTH      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SEND,
    STOP,
    ACK,
    WAIT_IDLE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] INH_LAST =
    CNT_WIDTH'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  state_e state_q, state_d;

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic data_s1_q, data_s2_q;

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [3:0] bit_q, bit_d;
  logic [7:0] byte_q, byte_d;
  logic par_q, par_d;
  logic clk_low_q, clk_low_d;
  logic data_low_q, data_low_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic fe;
  logic tmo;
  logic dev_st;

  assign fe  = clk_prev_q & ~clk_s2_q;
  assign tmo = (cnt_q == TMO_LAST);

  assign dev_st = (state_q == REQ) |
                  (state_q == SEND) |
                  (state_q == STOP) |
                  (state_q == ACK) |
                  (state_q == WAIT_IDLE);

  assign tx_ready     = rst_n & (state_q == IDLE);
  assign ps2_clk_low  = clk_low_q;
  assign ps2_data_low = data_low_q;
  assign done         = done_q;
  assign err          = err_q;

  // Two-flop line synchronizers plus previous clock level for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      data_s1_q  <= 1'b1;
      data_s2_q  <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      data_s1_q  <= ps2_data_i;
      data_s2_q  <= data_s1_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: device edges win over the timeout in the same cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (tx_valid) state_d = INHIBIT;
      end
      INHIBIT: begin
        if (cnt_q == INH_LAST) state_d = REQ;
      end
      REQ: begin
        if (fe) state_d = SEND;
        else if (tmo) state_d = IDLE;
      end
      SEND: begin
        if (fe && bit_q == 4'd8) state_d = STOP;
        else if (!fe && tmo) state_d = IDLE;
      end
      STOP: begin
        if (fe) state_d = ACK;
        else if (tmo) state_d = IDLE;
      end
      ACK: begin
        if (fe) state_d = data_s2_q ? IDLE : WAIT_IDLE;
        else if (tmo) state_d = IDLE;
      end
      WAIT_IDLE: begin
        if (clk_s2_q && data_s2_q) state_d = IDLE;
        else if (tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs and datapath next values, all registered below.
  always_comb begin
    cnt_d = (state_q == IDLE) ? '0 : cnt_q + CNT_WIDTH'(1);
    if (state_d != state_q || (fe && dev_st)) cnt_d = '0;
    bit_d      = bit_q;
    byte_d     = byte_q;
    par_d      = par_q;
    data_low_d = data_low_q;
    clk_low_d  = (state_d == INHIBIT);
    done_d     = (state_q == WAIT_IDLE) & clk_s2_q & data_s2_q;
    err_d      = dev_st & (state_d == IDLE) & ~done_d;
    unique case (state_q)
      IDLE: begin
        bit_d = 4'd0;
        if (tx_valid) begin
          byte_d = tx_data;
          par_d  = ~^tx_data;
        end
      end
      REQ: begin
        if (fe) begin
          bit_d      = 4'd1;
          data_low_d = ~byte_q[0];
        end
      end
      SEND: begin
        if (fe) begin
          bit_d      = bit_q + 4'd1;
          data_low_d = (bit_q == 4'd8) ? ~par_q
                                       : ~byte_q[bit_q[2:0]];
        end
      end
      STOP, ACK: begin
        if (fe) begin
          bit_d      = bit_q + 4'd1;
          data_low_d = 1'b0;
        end
      end
      default: ;
    endcase
    if (state_d == INHIBIT) data_low_d = (cnt_d == INH_LAST);
    if (state_d == REQ) data_low_d = 1'b1;
    if (state_d == IDLE) data_low_d = 1'b0;
  end

  // Datapath and registered line drivers / status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      bit_q      <= 4'd0;
      byte_q     <= 8'd0;
      par_q      <= 1'b0;
      clk_low_q  <= 1'b0;
      data_low_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      byte_q     <= byte_d;
      par_q      <= par_d;
      clk_low_q  <= clk_low_d;
      data_low_q <= data_low_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: device model, scoreboard of done/err outcomes,
// directed bytes with hand-computed parity.
module tb_ps2_tx;

  localparam int INH = 5000;
  localparam int TMO = 2000;

  localparam int K_ACK  = 0;
  localparam int K_NACK = 1;
  localparam int K_TMO  = 2;
  localparam int K_NONE = 3;

  typedef struct packed {
    logic        is_done;
    logic        chk;
    logic [10:0] frame;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       done;
  logic       err;

  logic dev_clk  = 1'b1;
  logic dev_data = 1'b1;
  logic line_clk;
  logic line_data;

  assign line_clk  = dev_clk & ~ps2_clk_low;
  assign line_data = dev_data & ~ps2_data_low;

  ps2_tx #(
    .INHIBIT_CYCLES(INH),
    .TIMEOUT_CYCLES(TMO),
    .CNT_WIDTH(20)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_i(line_clk),
    .ps2_data_i(line_data),
    .ps2_clk_low(ps2_clk_low),
    .ps2_data_low(ps2_data_low),
    .done(done),
    .err(err)
  );

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic expired(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // Device model
  int          dev_mode = 0;
  logic        dev_busy = 1'b0;
  int          dev_fe = 0;
  logic [10:0] dev_frame = '0;
  logic [10:0] dev_last_frame = '0;
  bit          rst_hit = 1'b0;

  task automatic dev_wait(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      if (!rst_n) rst_hit = 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dev_mode != 2 && line_clk && !line_data) begin
        dev_busy  = 1'b1;
        rst_hit   = 1'b0;
        dev_fe    = 0;
        dev_frame = '0;
        dev_frame[0] = line_data;
        dev_wait(20);
        for (int k = 1; k <= 11 && !rst_hit; k++) begin
          dev_clk = 1'b0;
          dev_fe  = k;
          dev_wait(40);
          if (!rst_hit && k <= 10) dev_frame[k] = line_data;
          if (!rst_hit && k == 10) dev_last_frame = dev_frame;
          dev_clk = 1'b1;
          if (!rst_hit && k == 10 && dev_mode == 0) dev_data = 1'b0;
          dev_wait(40);
        end
        dev_data = 1'b1;
        dev_busy = 1'b0;
      end
    end
  end

  // Scoreboard monitor
  exp_t e;
  always @(negedge clk) begin
    if (rst_n && (done || err)) begin
      check("done_err_excl", {31'd0, done & err}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got done=%0b err=%0b expected none",
                 done, err);
      end else begin
        e = exp_q.pop_front();
        check("outcome_done", {31'd0, done}, {31'd0, e.is_done});
        if (e.chk)
          check("frame", {21'd0, dev_last_frame}, {21'd0, e.frame});
      end
    end
  end

  // Inhibit-length monitor
  int inh_n = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      inh_n = 0;
    end else if (ps2_clk_low) begin
      inh_n++;
    end else if (inh_n != 0) begin
      check("inhibit_len", inh_n, INH);
      inh_n = 0;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_dev_idle();
    int n = 0;
    while (dev_busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (dev_busy) expired("dev_idle");
  endtask

  task automatic send(input logic [7:0] b, input logic par,
                      input int kind);
    exp_t x;
    int n = 0;
    wait_dev_idle();
    @(negedge clk);
    while (!tx_ready && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) expired("tx_ready");
    x.is_done = (kind == K_ACK);
    x.chk     = (kind == K_ACK) || (kind == K_NACK);
    x.frame   = {1'b1, par, b, 1'b0};
    if (kind != K_NONE) exp_q.push_back(x);
    tx_data  = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) expired("scoreboard_drain");
  endtask

  initial begin
    int n;
    logic seen;
    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    check("rst_clk_low", {31'd0, ps2_clk_low}, 32'd0);
    check("rst_data_low", {31'd0, ps2_data_low}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", {31'd0, tx_ready}, 32'd1);

    send(8'hED, 1'b1, K_ACK);
    wait_empty();
    send(8'h01, 1'b0, K_ACK);
    wait_empty();
    send(8'hFF, 1'b1, K_ACK);
    wait_empty();

    // NACK at the ack slot
    dev_mode = 1;
    send(8'h3C, 1'b1, K_NACK);
    n = 0;
    while (!err && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!err) expired("nack_err");
    check("nack_clk_rel", {31'd0, ps2_clk_low}, 32'd0);
    check("nack_data_rel", {31'd0, ps2_data_low}, 32'd0);
    check("nack_ready", {31'd0, tx_ready}, 32'd1);
    wait_empty();
    wait_dev_idle();
    dev_mode = 0;

    // Silent device: timeout measured from request entry
    dev_mode = 2;
    send(8'h55, 1'b1, K_TMO);
    n = 0;
    while (!ps2_clk_low && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (ps2_clk_low && n < 6000) begin
      @(negedge clk);
      n++;
    end
    check("req_data_low", {31'd0, ps2_data_low}, 32'd1);
    n = 0;
    while (!err && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!err) expired("timeout_err");
    check("timeout_cycles", n, TMO);
    check("tmo_clk_rel", {31'd0, ps2_clk_low}, 32'd0);
    check("tmo_data_rel", {31'd0, ps2_data_low}, 32'd0);
    check("tmo_ready", {31'd0, tx_ready}, 32'd1);
    wait_empty();
    dev_mode = 0;

    // Reset after the fourth device edge
    send(8'hED, 1'b1, K_NONE);
    n = 0;
    while (!(dev_busy && dev_fe == 4) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!(dev_busy && dev_fe == 4)) expired("fe4");
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_clk_low", {31'd0, ps2_clk_low}, 32'd0);
    check("midrst_data_low", {31'd0, ps2_data_low}, 32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd0);
    check("midrst_done_err", {30'd0, done, err}, 32'd0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_ready_rel", {31'd0, tx_ready}, 32'd1);
    wait_dev_idle();
    send(8'hF4, 1'b0, K_ACK);
    wait_empty();

    // 0xAA held valid while 0xED is in flight
    send(8'hED, 1'b1, K_ACK);
    tx_data  = 8'hAA;
    tx_valid = 1'b1;
    seen = 1'b0;
    n = 0;
    while (n < 20000) begin
      @(negedge clk);
      n++;
      if (done) break;
      if (tx_ready) seen = 1'b1;
    end
    tx_valid = 1'b0;
    if (!done) expired("hold_done");
    check("ready_low_busy", {31'd0, seen}, 32'd0);
    seen = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (ps2_clk_low) seen = 1'b1;
    end
    check("aa_not_sent", {31'd0, seen}, 32'd0);
    check("final_ready", {31'd0, tx_ready}, 32'd1);
    check("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
